// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_pad_ctrl : register-mapped GPIO controller driving bidir pad cells,
//                 with input synchronisers, edge detect and level interrupt.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module gpio_pad_ctrl #(
  parameter int NUM_PADS    = 18,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_valid,
  input  logic                bus_we,
  input  logic [3:0]          bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_ready,
  output logic                irq,
  input  logic [NUM_PADS-1:0] bidir_in,
  output logic [NUM_PADS-1:0] bidir_out,
  output logic [NUM_PADS-1:0] bidir_oe,
  output logic [NUM_PADS-1:0] bidir_cs,
  output logic [NUM_PADS-1:0] bidir_sl,
  output logic [NUM_PADS-1:0] bidir_ie,
  output logic [NUM_PADS-1:0] bidir_pu,
  output logic [NUM_PADS-1:0] bidir_pd
);

  localparam logic [3:0] A_OUT = 4'h0, A_OE = 4'h1, A_IN = 4'h2, A_PU = 4'h3;
  localparam logic [3:0] A_PD = 4'h4, A_CS = 4'h5, A_SL = 4'h6, A_IE = 4'h7;
  localparam logic [3:0] A_RISE = 4'h8, A_FALL = 4'h9, A_STAT = 4'hA;
  localparam logic [3:0] A_SET = 4'hB, A_CLR = 4'hC;
  localparam int         CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] ARM_DONE = CNT_W'(SYNC_STAGES + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t               state;
  logic [NUM_PADS-1:0]  out_reg, oe_reg, pu_reg, pd_reg, cs_reg, sl_reg, ie_reg;
  logic [NUM_PADS-1:0]  rise_en, fall_en, irq_status, prev_in;
  logic [NUM_PADS-1:0]  sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]     arm_cnt;

  logic                 access, wr;
  logic [NUM_PADS-1:0]  wd, in_sync, rise, fall, status_set, status_clr;
  logic [NUM_PADS-1:0]  rd_pads;
  logic [31:0]          rd_word;
  logic                 unused_wdata;

  assign access     = (state == IDLE) && bus_valid;
  assign wr         = access && bus_we;
  assign wd         = bus_wdata[NUM_PADS-1:0];
  assign unused_wdata = ^bus_wdata;
  assign in_sync    = sync_q[SYNC_STAGES-1];

  // Edges are masked until the synchronisers and prev have filled after reset
  assign rise       = (arm_cnt == ARM_DONE) ? (in_sync & ~prev_in) : '0;
  assign fall       = (arm_cnt == ARM_DONE) ? (~in_sync & prev_in) : '0;
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = (wr && bus_addr == A_STAT) ? wd : '0;

  assign bidir_out = out_reg;
  assign bidir_oe  = oe_reg;
  assign bidir_cs  = cs_reg;
  assign bidir_sl  = sl_reg;
  assign bidir_ie  = ie_reg;
  assign bidir_pu  = pu_reg;
  assign bidir_pd  = pd_reg;

  always_comb begin
    rd_pads = '0;
    case (bus_addr)
      A_OUT:   rd_pads = out_reg;
      A_OE:    rd_pads = oe_reg;
      A_IN:    rd_pads = in_sync;
      A_PU:    rd_pads = pu_reg;
      A_PD:    rd_pads = pd_reg;
      A_CS:    rd_pads = cs_reg;
      A_SL:    rd_pads = sl_reg;
      A_IE:    rd_pads = ie_reg;
      A_RISE:  rd_pads = rise_en;
      A_FALL:  rd_pads = fall_en;
      A_STAT:  rd_pads = irq_status;
      default: rd_pads = '0;
    endcase
    rd_word = '0;
    rd_word[NUM_PADS-1:0] = rd_pads;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_in <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= bidir_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_in <= in_sync;
      if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_ready  <= 1'b0;
      bus_rdata  <= '0;
      irq        <= 1'b0;
      irq_status <= '0;
      out_reg    <= '0;
      oe_reg     <= '0;
      pu_reg     <= '0;
      pd_reg     <= '0;
      cs_reg     <= '0;
      sl_reg     <= '0;
      ie_reg     <= '1;
      rise_en    <= '0;
      fall_en    <= '0;
    end else begin
      // Set has priority over a same-cycle W1C
      irq_status <= (irq_status & ~status_clr) | status_set;
      irq        <= |irq_status;
      bus_ready  <= access;
      state      <= access ? RESP : IDLE;
      if (access && !bus_we) bus_rdata <= rd_word;
      if (wr) begin
        case (bus_addr)
          A_OUT:   out_reg <= wd;
          A_OE:    oe_reg  <= wd;
          A_PU:    pu_reg  <= wd;
          A_PD:    pd_reg  <= wd;
          A_CS:    cs_reg  <= wd;
          A_SL:    sl_reg  <= wd;
          A_IE:    ie_reg  <= wd;
          A_RISE:  rise_en <= wd;
          A_FALL:  fall_en <= wd;
          A_SET:   out_reg <= out_reg | wd;
          A_CLR:   out_reg <= out_reg & ~wd;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gpio_pad_ctrl : directed self-checking bench for gpio_pad_ctrl.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_gpio_pad_ctrl;

  localparam int NUM_PADS = 18;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                bus_valid = 1'b0;
  logic                bus_we = 1'b0;
  logic [3:0]          bus_addr = '0;
  logic [31:0]         bus_wdata = '0;
  logic [31:0]         bus_rdata;
  logic                bus_ready;
  logic                irq;
  logic [NUM_PADS-1:0] bidir_in = 18'h3FFFF;
  logic [NUM_PADS-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl;
  logic [NUM_PADS-1:0] bidir_ie, bidir_pu, bidir_pd;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  gpio_pad_ctrl #(.NUM_PADS(NUM_PADS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .irq(irq), .bidir_in(bidir_in),
    .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs),
    .bidir_sl(bidir_sl), .bidir_ie(bidir_ie), .bidir_pu(bidir_pu),
    .bidir_pd(bidir_pd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One idle cycle, then a request held until bus_ready (bounded)
  task automatic bus_xfer(input logic we, input logic [3:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus_ready && n < 8);
    check_eq("ack_latency", 32'(n), 32'd1);
    rdata = bus_rdata;
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, addr, 32'h0, v);
    check_eq(tag, v, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with pads static high
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_ie",    32'(bidir_ie), 32'h3FFFF);
    check_eq("rst_out",   32'(bidir_out | bidir_oe | bidir_cs | bidir_sl | bidir_pu | bidir_pd), 32'h0);
    check_eq("rst_ready", 32'(bus_ready), 32'h0);
    check_eq("rst_irq",   32'(irq), 32'h0);
    check_eq("rst_rdata", bus_rdata, 32'h0);
    wr(4'h8, 32'h3FFFF);
    cycles(8);
    check_eq("static_hi_irq", 32'(irq), 32'h0);
    rd_chk("static_hi_status", 4'hA, 32'h0);
    wr(4'h8, 32'h0);
    bidir_in = '0;
    cycles(5);

    // Output registers, set/clear aliases
    wr(4'h0, 32'h000000A5);
    wr(4'h1, 32'h000000FF);
    rd_chk("out_rd", 4'h0, 32'h000000A5);
    check_eq("pad_out", 32'(bidir_out), 32'h000A5);
    check_eq("pad_oe",  32'(bidir_oe),  32'h000FF);
    wr(4'h0, 32'h00000033);
    check_eq("wr_keeps_rdata", bus_rdata, 32'h000000A5);
    wr(4'h0, 32'h000000A5);
    wr(4'hB, 32'h00000100);
    wr(4'hC, 32'h00000005);
    wr(4'hB, 32'h00000000);
    wr(4'hC, 32'h00000000);
    rd_chk("out_setclr", 4'h0, 32'h000001A0);
    rd_chk("set_alias_rd0", 4'hB, 32'h0);

    // Rising edge interrupt and W1C
    wr(4'h8, 32'h1);
    bidir_in[0] = 1'b1;
    cycles(5);
    check_eq("rise_irq", 32'(irq), 32'h1);
    rd_chk("in_rd", 4'h2, 32'h1);
    rd_chk("rise_status", 4'hA, 32'h1);
    wr(4'hA, 32'h0);
    rd_chk("w0_keeps_status", 4'hA, 32'h1);
    wr(4'hA, 32'h1);
    cycles(1);
    check_eq("irq_clear", 32'(irq), 32'h0);
    rd_chk("status_cleared", 4'hA, 32'h0);

    // Falling edge coinciding with W1C: set wins
    wr(4'h9, 32'h2);
    bidir_in[1] = 1'b1;
    cycles(5);
    rd_chk("no_rise_bit1", 4'hA, 32'h0);
    bidir_in[1] = 1'b0;
    cycles(1);
    wr(4'hA, 32'h2);
    rd_chk("set_wins", 4'hA, 32'h2);
    wr(4'hA, 32'h2);
    rd_chk("fall_cleared", 4'hA, 32'h0);

    // Width masking and reserved addresses
    wr(4'h3, 32'hFFFFFFFF);
    rd_chk("pu_masked", 4'h3, 32'h0003FFFF);
    check_eq("pad_pu", 32'(bidir_pu), 32'h3FFFF);
    wr(4'hE, 32'h12345678);
    rd_chk("reserved_rd0", 4'hE, 32'h0);

    // Reset asserted while a read response is presented
    @(posedge clk); #1;
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
    @(posedge clk); #1;
    check_eq("mid_resp_ready", 32'(bus_ready), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(bus_ready), 32'h0);
    check_eq("mid_rst_out",   32'(bidir_out | bidir_pu), 32'h0);
    check_eq("mid_rst_ie",    32'(bidir_ie), 32'h3FFFF);
    check_eq("mid_rst_rdata", bus_rdata, 32'h0);
    bus_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_chk("post_rst_out", 4'h0, 32'h0);
    rd_chk("post_rst_ie",  4'h7, 32'h0003FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
